dcache_dm_wb: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that is the responder on the dcache interface driven by the MEM stage. It accepts one word-aligned read or masked write at a time, answers hits in one cycle, and on a miss evicts a dirty line and refills word-by-word through the memory controller port. It is a drop-in alternative behind the same cpu-side interface.

---
 rtl/dcache_pkg.sv | 40 ++++
 rtl/dcache_burst_engine.sv | 89 ++++++++
 rtl/dcache_dm_wb.sv | 183 ++++++++++++++++++
 tb/tb_dcache_dm_wb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;

   localparam int BYTE_W  = 2;
   localparam int TAG_MAX = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPARE,
      S_EVICT,
      S_REFILL
   } state_e;

   typedef enum logic [1:0] {
      B_IDLE,
      B_REQ,
      B_WAIT
   } burst_e;

   typedef struct packed {
      logic               valid;
      logic               dirty;
      logic [TAG_MAX-1:0] tag;
   } line_meta_t;

   function automatic int word_bits(input int words);
      return $clog2(words);
   endfunction

   function automatic int index_bits(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_bits(input int aw, input int lines,
                                   input int words);
      return aw - BYTE_W - $clog2(lines) - $clog2(words);
   endfunction

endpackage

// File: rtl/dcache_burst_engine.sv
// Sequences one line's worth of single-word memory transactions,
// one outstanding request at a time, for eviction and refill.
module dcache_burst_engine
   import dcache_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int WORDS = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       start,
   input  logic                       start_we,
   input  logic [AW-1:0]              start_addr,
   input  logic [DW-1:0]              wr_word,
   output logic [word_bits(WORDS)-1:0] word_idx,
   output logic                       rsp_valid,
   output logic [DW-1:0]              rsp_data,
   output logic                       done,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic                       mem_req_we,
   output logic [AW-1:0]              mem_req_addr,
   output logic [DW-1:0]              mem_req_wdata,
   input  logic                       mem_res_valid,
   input  logic [DW-1:0]              mem_res_rdata
);

   localparam int WW = word_bits(WORDS);

   burst_e        st_q, st_d;
   logic [WW-1:0] cnt_q, cnt_d;
   logic          we_q;
   logic [AW-1:0] base_q;
   logic          last;
   logic          resp;

   assign last = (cnt_q == WW'(WORDS - 1));
   assign resp = (st_q == B_WAIT) && mem_res_valid;

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
         B_REQ: begin
            if (mem_req_ready) st_d = B_WAIT;
         end
         B_WAIT: begin
            if (resp) begin
               st_d  = last ? B_IDLE : B_REQ;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: st_d = st_q;
      endcase
      // a new burst may be chained in the cycle the previous one ends
      if (start) begin
         st_d  = B_REQ;
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         st_q   <= B_IDLE;
         cnt_q  <= '0;
         we_q   <= 1'b0;
         base_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         if (start) begin
            we_q   <= start_we;
            base_q <= start_addr;
         end
      end
   end

   assign mem_req_valid = (st_q == B_REQ);
   assign mem_req_we    = mem_req_valid && we_q;
   assign mem_req_addr  = base_q + AW'({cnt_q, 2'b00});
   assign mem_req_wdata = mem_req_we ? wr_word : '0;

   assign word_idx  = cnt_q;
   assign rsp_valid = resp;
   assign rsp_data  = mem_res_rdata;
   assign done      = resp && last;

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache answering the
// MEM stage; misses evict and refill through a single-word memory port.
module dcache_dm_wb
   import dcache_pkg::*;
#(
   parameter int DATA_LENGTH    = 32,
   parameter int ADDR_LENGTH    = 32,
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   valid,
   output logic                   ready,
   input  logic                   rw,
   input  logic [ADDR_LENGTH-1:0] addr,
   input  logic [DATA_LENGTH-1:0] wdata,
   input  logic [DATA_LENGTH-1:0] wmask,
   output logic [DATA_LENGTH-1:0] rdata,
   output logic                   rvalid,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic                   mem_req_we,
   output logic [ADDR_LENGTH-1:0] mem_req_addr,
   output logic [DATA_LENGTH-1:0] mem_req_wdata,
   input  logic                   mem_res_valid,
   input  logic [DATA_LENGTH-1:0] mem_res_rdata
);

   localparam int OFF_W = word_bits(WORDS_PER_LINE);
   localparam int IDX_W = index_bits(NUM_LINES);
   localparam int TAG_W = tag_bits(ADDR_LENGTH, NUM_LINES, WORDS_PER_LINE);
   localparam int LOW_W = OFF_W + BYTE_W;

   state_e st_q, st_d;

   logic                          req_rw_q;
   logic [ADDR_LENGTH-1:BYTE_W]   req_addr_q;
   logic [DATA_LENGTH-1:0]        req_wdata_q;
   logic [DATA_LENGTH-1:0]        req_wmask_q;

   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] woff;
   logic [TAG_W-1:0] tag;

   logic [NUM_LINES-1:0]   valid_q;
   logic [NUM_LINES-1:0]   dirty_q;
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];
   logic [DATA_LENGTH-1:0] data_q [NUM_LINES][WORDS_PER_LINE];

   line_meta_t             line;
   logic                   hit;
   logic [DATA_LENGTH-1:0] old_word;
   logic [DATA_LENGTH-1:0] merged;
   logic                   wr_hit;

   logic                   eng_start;
   logic                   eng_we;
   logic [ADDR_LENGTH-1:0] eng_addr;
   logic [OFF_W-1:0]       eng_word;
   logic                   eng_rsp;
   logic [DATA_LENGTH-1:0] eng_data;
   logic                   eng_done;

   logic                   unused_addr;

   assign unused_addr = ^addr[BYTE_W-1:0];

   assign idx  = req_addr_q[LOW_W +: IDX_W];
   assign woff = req_addr_q[BYTE_W +: OFF_W];
   assign tag  = req_addr_q[ADDR_LENGTH-1 -: TAG_W];

   assign line = '{valid: valid_q[idx],
                   dirty: dirty_q[idx],
                   tag:   TAG_MAX'(tag_q[idx])};

   assign hit      = line.valid && (line.tag == TAG_MAX'(tag));
   assign old_word = data_q[idx][woff];
   assign merged   = (old_word & ~req_wmask_q) | (req_wdata_q & req_wmask_q);
   assign ready    = (st_q == S_IDLE);

   always_comb begin
      st_d      = st_q;
      eng_start = 1'b0;
      eng_we    = 1'b0;
      eng_addr  = '0;
      rvalid    = 1'b0;
      rdata     = '0;
      wr_hit    = 1'b0;
      unique case (st_q)
         S_IDLE: begin
            if (valid) st_d = S_COMPARE;
         end
         S_COMPARE: begin
            if (hit) begin
               rvalid = 1'b1;
               rdata  = req_rw_q ? merged : old_word;
               wr_hit = req_rw_q;
               st_d   = S_IDLE;
            end else if (line.valid && line.dirty) begin
               eng_start = 1'b1;
               eng_we    = 1'b1;
               eng_addr  = {line.tag[TAG_W-1:0], idx, {LOW_W{1'b0}}};
               st_d      = S_EVICT;
            end else begin
               eng_start = 1'b1;
               eng_addr  = {tag, idx, {LOW_W{1'b0}}};
               st_d      = S_REFILL;
            end
         end
         S_EVICT: begin
            if (eng_done) begin
               eng_start = 1'b1;
               eng_addr  = {tag, idx, {LOW_W{1'b0}}};
               st_d      = S_REFILL;
            end
         end
         S_REFILL: begin
            if (eng_done) st_d = S_COMPARE;
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         st_q        <= S_IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         req_rw_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wmask_q <= '0;
      end else begin
         st_q <= st_d;
         if (valid && ready) begin
            req_rw_q    <= rw;
            req_addr_q  <= addr[ADDR_LENGTH-1:BYTE_W];
            req_wdata_q <= wdata;
            req_wmask_q <= wmask;
         end
         if (eng_start && !eng_we) valid_q[idx] <= 1'b0;
         if (st_q == S_EVICT && eng_done) dirty_q[idx] <= 1'b0;
         if (st_q == S_REFILL && eng_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
         if (wr_hit) dirty_q[idx] <= 1'b1;
      end
   end

   // data and tags carry no reset; the valid bits guard them
   always_ff @(posedge i_clk) begin
      if (st_q == S_REFILL && eng_rsp) data_q[idx][eng_word] <= eng_data;
      if (st_q == S_REFILL && eng_done) tag_q[idx] <= tag;
      if (wr_hit) data_q[idx][woff] <= merged;
   end

   dcache_burst_engine #(
      .AW    (ADDR_LENGTH),
      .DW    (DATA_LENGTH),
      .WORDS (WORDS_PER_LINE)
   ) u_burst (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .start         (eng_start),
      .start_we      (eng_we),
      .start_addr    (eng_addr),
      .wr_word       (data_q[idx][eng_word]),
      .word_idx      (eng_word),
      .rsp_valid     (eng_rsp),
      .rsp_data      (eng_data),
      .done          (eng_done),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_res_valid (mem_res_valid),
      .mem_res_rdata (mem_res_rdata)
   );

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Randomized bench for dcache_dm_wb: flat-memory golden model plus a
// line-residency model predicting every memory transaction.
module tb_dcache_dm_wb;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        valid = 1'b0;
   logic        ready;
   logic        rw = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] wmask = '0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_res_valid = 1'b0;
   logic [31:0] mem_res_rdata = '0;

   always #5 i_clk = ~i_clk;

   dcache_dm_wb dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .valid         (valid),
      .ready         (ready),
      .rw            (rw),
      .addr          (addr),
      .wdata         (wdata),
      .wmask         (wmask),
      .rdata         (rdata),
      .rvalid        (rvalid),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_res_valid (mem_res_valid),
      .mem_res_rdata (mem_res_rdata)
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   int total = 0;
   int bad = 0;

   txn_t exp_q[$];
   txn_t log_q[$];

   bit          m_valid [16];
   bit          m_dirty [16];
   logic [23:0] m_tag   [16];
   logic [31:0] golden [int unsigned];
   logic [31:0] memm   [int unsigned];

   bit          pending = 0;
   bit          exp_hit = 0;
   logic [31:0] exp_rdata = '0;
   logic [31:0] last_rdata = '0;
   int          cyc = 0;
   int          reads_seen = 0;
   int          stall_left = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req,
                  $time);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      logic [31:0] v;
      v = 32'h1000_0000 + ((a >> 2) & 32'h3) + (a & 32'hFFFF_FC00);
      v = v + ((((a >> 4) & 32'hF) ^ 32'h4) << 20);
      return v;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      int unsigned k = a;
      return memm.exists(k) ? memm[k] : dflt(a);
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      int unsigned k = a;
      return golden.exists(k) ? golden[k] : dflt(a);
   endfunction

   task automatic predict(input bit w, input logic [31:0] a0,
                          input logic [31:0] wd, input logic [31:0] wm);
      logic [31:0] a;
      logic [31:0] base;
      logic [31:0] vb;
      logic [31:0] nv;
      logic [3:0]  ix;
      logic [23:0] tg;
      txn_t        t;
      a    = a0 & ~32'h3;
      base = a & ~32'hF;
      ix   = a[7:4];
      tg   = a[31:8];
      exp_hit = m_valid[ix] && (m_tag[ix] == tg);
      if (!exp_hit) begin
         if (m_valid[ix] && m_dirty[ix]) begin
            vb = {m_tag[ix], ix, 4'h0};
            for (int i = 0; i < 4; i++) begin
               t.we = 1; t.addr = vb + 32'(4 * i);
               t.data = gold_rd(t.addr);
               exp_q.push_back(t);
            end
         end
         for (int i = 0; i < 4; i++) begin
            t.we = 0; t.addr = base + 32'(4 * i); t.data = '0;
            exp_q.push_back(t);
         end
         m_valid[ix] = 1; m_tag[ix] = tg; m_dirty[ix] = 0;
      end
      if (w) begin
         nv = (gold_rd(a) & ~wm) | (wd & wm);
         golden[a] = nv;
         m_dirty[ix] = 1;
         exp_rdata = nv;
      end else begin
         exp_rdata = gold_rd(a);
      end
   endtask

   task automatic issue(input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] wm);
      predict(w, a, wd, wm);
      @(negedge i_clk);
      #2;
      valid = 1; rw = w; addr = a; wdata = wd; wmask = wm;
      @(posedge i_clk);
      #1;
      pending = 1;
      cyc = 0;
      valid = 0;
      rw = 1'($urandom);
      addr = $urandom;
      wdata = $urandom;
      wmask = $urandom;
   endtask

   task automatic do_req(input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] wm);
      issue(w, a, wd, wm);
      for (int k = 0; k < 600; k++) begin
         @(negedge i_clk);
         #3;
         if (!pending) break;
      end
      if (pending) begin
         chk("req_timeout", 32'd1, 32'd0);
         pending = 0;
      end
      chk("mem_traffic_drained", exp_q.size(), 0);
   endtask

   // cpu-side compare: readiness, completion timing and data
   initial begin
      forever begin
         @(negedge i_clk);
         if (!i_reset_n) continue;
         if (pending) begin
            cyc++;
            chk("ready_busy", ready, 0);
            if (rvalid) begin
               chk("rdata", rdata, exp_rdata);
               if (exp_hit) chk("hit_latency", cyc, 1);
               last_rdata = rdata;
               pending = 0;
            end
         end else begin
            chk("ready_idle", ready, 1);
            chk("idle_no_rvalid", rvalid, 0);
            chk("idle_no_mem_req", mem_req_valid, 0);
         end
      end
   end

   // memory controller model with random ready and response delay
   initial begin
      int          resp_cnt = -1;
      bit          outstanding = 0;
      bit          prev_stall = 0;
      logic [31:0] p_addr = '0;
      logic [31:0] p_wdata = '0;
      bit          p_we = 0;
      logic [31:0] resp_data = '0;
      txn_t        t;
      forever begin
         @(negedge i_clk);
         mem_res_valid = 0;
         if (!i_reset_n) begin
            resp_cnt = -1; outstanding = 0; prev_stall = 0;
            mem_req_ready = 0;
            continue;
         end
         if (prev_stall) begin
            chk("req_stable_valid", mem_req_valid, 1);
            chk("req_stable_addr", mem_req_addr, p_addr);
            chk("req_stable_we", mem_req_we, p_we);
            chk("req_stable_wdata", mem_req_wdata, p_wdata);
         end
         if (resp_cnt > 0) begin
            resp_cnt--;
         end else if (resp_cnt == 0) begin
            mem_res_valid = 1;
            mem_res_rdata = resp_data;
            resp_cnt = -1;
            outstanding = 0;
         end
         if (!mem_res_valid) mem_res_rdata = $urandom;
         if (stall_left > 0 && mem_req_valid) begin
            mem_req_ready = 0;
            stall_left--;
         end else begin
            mem_req_ready = ($urandom % 4) != 0;
         end
         prev_stall = mem_req_valid && !mem_req_ready;
         p_addr = mem_req_addr; p_we = mem_req_we; p_wdata = mem_req_wdata;
         if (mem_req_valid && mem_req_ready) begin
            chk("one_outstanding", outstanding, 0);
            chk("req_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               t = exp_q.pop_front();
               chk("req_addr", mem_req_addr, t.addr);
               chk("req_we", mem_req_we, t.we);
               if (t.we) chk("req_wdata", mem_req_wdata, t.data);
            end
            t.we = mem_req_we; t.addr = mem_req_addr; t.data = mem_req_wdata;
            log_q.push_back(t);
            if (mem_req_we) begin
               memm[mem_req_addr] = mem_req_wdata;
               resp_data = $urandom;
            end else begin
               resp_data = mem_rd(mem_req_addr);
               reads_seen++;
            end
            resp_cnt = $urandom % 3;
            outstanding = 1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic reset_model();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0; m_dirty[i] = 0;
      end
      exp_q.delete();
      golden = memm;
      pending = 0;
   endtask

   initial begin
      reset_model();
      #23;
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_req_we", mem_req_we, 0);
      chk("rst_mem_req_addr", mem_req_addr, 0);
      chk("rst_mem_req_wdata", mem_req_wdata, 0);
      @(negedge i_clk);
      #2;
      i_reset_n = 1;
      @(negedge i_clk);
      #3;

      log_q.delete();
      do_req(0, 32'h40, 0, 0);
      chk("t1_rdata", last_rdata, 32'h1000_0000);
      chk("t1_nreq", log_q.size(), 4);
      chk("t1_addr0", log_q[0].addr, 32'h40);
      chk("t1_addr3", log_q[3].addr, 32'h4C);

      log_q.delete();
      do_req(0, 32'h44, 0, 0);
      chk("t2_rdata", last_rdata, 32'h1000_0001);
      chk("t2_nreq", log_q.size(), 0);

      do_req(1, 32'h44, 32'hAABB_CCDD, 32'h0000_FF00);
      chk("t3_wr_rdata", last_rdata, 32'h1000_CC01);
      do_req(0, 32'h44, 0, 0);
      chk("t3_rd_rdata", last_rdata, 32'h1000_CC01);

      log_q.delete();
      do_req(0, 32'h440, 0, 0);
      chk("t4_nreq", log_q.size(), 8);
      chk("t4_ev_we", 32'(log_q[1].we), 1);
      chk("t4_ev_addr", log_q[1].addr, 32'h44);
      chk("t4_ev_data", log_q[1].data, 32'h1000_CC01);
      chk("t4_rf_addr0", log_q[4].addr, 32'h440);
      chk("t4_rf_addr3", log_q[7].addr, 32'h44C);
      do_req(0, 32'h44, 0, 0);
      chk("t4_back_rdata", last_rdata, 32'h1000_CC01);

      stall_left = 5;
      do_req(0, 32'h800, 0, 0);
      chk("t5_rdata", last_rdata, 32'h1040_0800);
      chk("t5_stall_used", stall_left, 0);

      reads_seen = 0;
      issue(0, 32'hC50, 0, 0);
      for (int k = 0; k < 400; k++) begin
         @(negedge i_clk);
         #3;
         if (reads_seen >= 2) break;
      end
      chk("t6_reached_word2", reads_seen >= 2, 1);
      i_reset_n = 0;
      #1;
      chk("t6_rst_rvalid", rvalid, 0);
      chk("t6_rst_rdata", rdata, 0);
      chk("t6_rst_mem_req_valid", mem_req_valid, 0);
      chk("t6_rst_mem_req_we", mem_req_we, 0);
      chk("t6_rst_mem_req_addr", mem_req_addr, 0);
      chk("t6_rst_mem_req_wdata", mem_req_wdata, 0);
      @(negedge i_clk);
      @(negedge i_clk);
      reset_model();
      #2;
      i_reset_n = 1;
      @(negedge i_clk);
      #3;
      log_q.delete();
      do_req(0, 32'hC50, 0, 0);
      chk("t6_reread_nreq", log_q.size(), 4);
      chk("t6_reread_addr0", log_q[0].addr, 32'hC50 & ~32'hF);
      chk("t6_reread_rdata", last_rdata, 32'h1010_0C00);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         logic [31:0] m;
         a = {22'd0, 2'($urandom), 4'($urandom), 2'($urandom), 2'($urandom)};
         m = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
         do_req(1'($urandom), a, $urandom, m);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
